// File: rtl/hilo_muldiv_ctrl_pkg.sv
// rtl/hilo_muldiv_ctrl_pkg.sv - shared op encoding, FSM states and constants for the HI/LO sequencer
package hilo_muldiv_ctrl_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MADD  = 4'd5,
        OP_MADDU = 4'd6,
        OP_MSUB  = 4'd7,
        OP_MSUBU = 4'd8,
        OP_MUL   = 4'd9,
        OP_MTHI  = 4'd10,
        OP_MTLO  = 4'd11
    } muldiv_op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIX,
        ST_DONE
    } muldiv_state_t;

    localparam int MULDIV_DIV_ITERS = 32;

    function automatic logic is_mul_class(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_MULTU) || (o == OP_MADD) || (o == OP_MADDU) ||
               (o == OP_MSUB) || (o == OP_MSUBU) || (o == OP_MUL);
    endfunction

    function automatic logic is_signed_mul(input muldiv_op_t o);
        return (o == OP_MULT) || (o == OP_MADD) || (o == OP_MSUB) || (o == OP_MUL);
    endfunction

endpackage

// File: rtl/div_radix2.sv
// rtl/div_radix2.sv - iterative unsigned restoring divider, one quotient bit per step
module div_radix2 (
    input  logic        clk,
    input  logic        resetn,
    input  logic        clear,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    logic [31:0] quo_q;
    logic [31:0] rem_q;
    logic [31:0] dvsr_q;
    logic [32:0] trial;
    logic        ge;

    // quo_q starts as the dividend and is shifted out MSB-first as quotient bits shift in
    assign trial = {rem_q, quo_q[31]};
    assign ge    = trial >= {1'b0, dvsr_q};

    always_ff @(posedge clk) begin
        if (!resetn) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else if (clear) begin
            quo_q  <= dividend;
            rem_q  <= '0;
            dvsr_q <= divisor;
        end else if (step) begin
            quo_q <= {quo_q[30:0], ge};
            rem_q <= ge ? (trial[31:0] - dvsr_q) : trial[31:0];
        end
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// rtl/hilo_muldiv_ctrl.sv - multi-cycle multiply/divide sequencer owning architectural HI/LO
module hilo_muldiv_ctrl
    import hilo_muldiv_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    muldiv_state_t state_q, state_d;
    muldiv_op_t    op_in, op_q;
    logic [4:0]    cnt_q;
    logic          load_mul, load_div, div_step, commit, mt_hi, mt_lo;

    logic [32:0]   ma_q, mb_q;
    logic [63:0]   base_q;
    logic [63:0]   prod_comb, prod_final;

    logic          div_signed;
    logic          quo_neg_q, rem_neg_q;
    logic [31:0]   div_quo, div_rem, quo_fix, rem_fix;

    assign op_in = muldiv_op_t'(op);

    always_comb begin
        state_d  = state_q;
        stall    = 1'b0;
        load_mul = 1'b0;
        load_div = 1'b0;
        div_step = 1'b0;
        commit   = 1'b0;
        mt_hi    = 1'b0;
        mt_lo    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    if (op_in == OP_MTHI) begin
                        mt_hi = 1'b1;
                    end else if (op_in == OP_MTLO) begin
                        mt_lo = 1'b1;
                    end else if (is_mul_class(op_in)) begin
                        load_mul = 1'b1;
                        stall    = 1'b1;
                        state_d  = ST_MUL;
                    end else if (op_in == OP_DIV || op_in == OP_DIVU) begin
                        load_div = 1'b1;
                        stall    = 1'b1;
                        state_d  = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 5'd0) begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DIV: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    div_step = 1'b1;
                    if (cnt_q == 5'd0) state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                stall = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign done = (state_q == ST_DONE);

    // 33-bit operands widened to 64: the low 64 bits of the product are exact for both signednesses
    assign prod_comb = {{31{ma_q[32]}}, ma_q} * {{31{mb_q[32]}}, mb_q};

    generate
        if (MUL_LAT == 1) begin : g_no_pipe
            assign prod_final = prod_comb;
        end else begin : g_pipe
            logic [63:0] pipe_q [MUL_LAT-1];
            always_ff @(posedge clk) begin
                pipe_q[0] <= prod_comb;
                for (int i = 1; i < MUL_LAT - 1; i++) pipe_q[i] <= pipe_q[i-1];
            end
            assign prod_final = pipe_q[MUL_LAT-2];
        end
    endgenerate

    assign div_signed = (op_in == OP_DIV);

    div_radix2 u_div (
        .clk       (clk),
        .resetn    (resetn),
        .clear     (load_div),
        .step      (div_step),
        .dividend  ((div_signed && a[31]) ? -a : a),
        .divisor   ((div_signed && b[31]) ? -b : b),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign quo_fix = quo_neg_q ? -div_quo : div_quo;
    assign rem_fix = rem_neg_q ? -div_rem : div_rem;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_NONE;
            cnt_q     <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            base_q    <= '0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            result    <= '0;
        end else begin
            state_q <= state_d;
            if (mt_hi) hi <= a;
            if (mt_lo) lo <= a;

            if (load_mul) begin
                op_q   <= op_in;
                ma_q   <= {is_signed_mul(op_in) & a[31], a};
                mb_q   <= {is_signed_mul(op_in) & b[31], b};
                base_q <= {hi, lo};
                cnt_q  <= 5'(MUL_LAT - 1);
            end else if (load_div) begin
                op_q      <= op_in;
                cnt_q     <= 5'(MULDIV_DIV_ITERS - 1);
                // a zero divisor yields all-ones quotient that must not be negated
                quo_neg_q <= div_signed && (a[31] ^ b[31]) && (b != 32'd0);
                rem_neg_q <= div_signed && a[31];
            end else if ((state_q == ST_MUL || state_q == ST_DIV) && cnt_q != 5'd0) begin
                cnt_q <= cnt_q - 5'd1;
            end

            if (commit) begin
                case (op_q)
                    OP_DIV, OP_DIVU: begin
                        hi <= rem_fix;
                        lo <= quo_fix;
                    end
                    OP_MUL:            result    <= prod_final[31:0];
                    OP_MADD, OP_MADDU: {hi, lo}  <= base_q + prod_final;
                    OP_MSUB, OP_MSUBU: {hi, lo}  <= base_q - prod_final;
                    default:           {hi, lo}  <= prod_final;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// tb/tb_hilo_muldiv_ctrl.sv - directed-vector bench for the HI/LO multiply/divide sequencer
module tb_hilo_muldiv_ctrl;
    import hilo_muldiv_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall, done;
    logic [31:0] result, hi, lo;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    hilo_muldiv_ctrl #(.MUL_LAT(2)) dut (
        .clk    (clk),
        .resetn (resetn),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    // Issues one op at cycle 0 and reports the done cycle, stall count and result at done
    task automatic do_op(input logic [3:0] o, input logic [31:0] va, input logic [31:0] vb,
                         output int done_cyc, output int stall_cnt, output logic [31:0] res);
        start = 1'b1; op = o; a = va; b = vb;
        done_cyc = -1; stall_cnt = 0; res = 'x;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (stall) stall_cnt++;
            if (done) begin done_cyc = c; res = result; end
            @(posedge clk); #1;
            start = 1'b0;
            if (done_cyc >= 0) break;
        end
    endtask

    task automatic mt(input logic [3:0] o, input logic [31:0] v);
        start = 1'b1; op = o; a = v;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi: got %h expected %h", hi, 32'd0); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo: got %h expected %h", lo, 32'd0); end
        vectors++; if (result !== 32'd0) begin miscompares++; $display("FAIL reset_result: got %h expected %h", result, 32'd0); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b expected 0", done); end
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL reset_stall: got %b expected 0", stall); end
        resetn = 1'b1;
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0 || stall !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle: got done=%b stall=%b expected 0/0", done, stall); end
    endtask

    task automatic test_mult;
        int dc, sc;
        logic [31:0] r;
        do_op(OP_MULT, 32'hFFFF_FFFE, 32'd3, dc, sc, r);
        vectors++; if (dc !== 3) begin miscompares++; $display("FAIL mult_done_cycle: got %0d expected 3", dc); end
        vectors++; if (sc !== 3) begin miscompares++; $display("FAIL mult_stall_cycles: got %0d expected 3", sc); end
        vectors++; if (hi !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mult_hi: got %h expected ffffffff", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL mult_lo: got %h expected fffffffa", lo); end
        do_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, dc, sc, r);
        vectors++; if (dc !== 3) begin miscompares++; $display("FAIL multu_done_cycle: got %0d expected 3", dc); end
        vectors++; if (hi !== 32'd2) begin miscompares++; $display("FAIL multu_hi: got %h expected 00000002", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFA) begin miscompares++; $display("FAIL multu_lo: got %h expected fffffffa", lo); end
    endtask

    task automatic test_div;
        int dc, sc;
        logic [31:0] r;
        logic [3:0]  ops [6];
        logic [31:0] va [6], vb [6], ehi [6], elo [6];
        ops = '{OP_DIV, OP_DIV, OP_DIVU, OP_DIV, OP_DIVU, OP_DIV};
        va  = '{32'hFFFF_FFF9, 32'd7, 32'd7, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 32'h8000_0000};
        vb  = '{32'd2, 32'hFFFF_FFFE, 32'd0, 32'd0, 32'h10, 32'hFFFF_FFFF};
        elo = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0FFF_FFFF, 32'h8000_0000};
        ehi = '{32'hFFFF_FFFF, 32'd1, 32'd7, 32'hFFFF_FFF9, 32'hF, 32'd0};
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], va[i], vb[i], dc, sc, r);
            vectors++; if (dc !== 34) begin miscompares++; $display("FAIL div%0d_done_cycle: got %0d expected 34", i, dc); end
            vectors++; if (sc !== 34) begin miscompares++; $display("FAIL div%0d_stall_cycles: got %0d expected 34", i, sc); end
            vectors++; if (lo !== elo[i]) begin miscompares++; $display("FAIL div%0d_lo: got %h expected %h", i, lo, elo[i]); end
            vectors++; if (hi !== ehi[i]) begin miscompares++; $display("FAIL div%0d_hi: got %h expected %h", i, hi, ehi[i]); end
        end
    endtask

    task automatic test_madd;
        int dc, sc;
        logic [31:0] r;
        mt(OP_MTLO, 32'hFFFF_FFFF);
        start = 1'b1; op = OP_MTHI; a = 32'h1234;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL mthi_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        start = 1'b0;
        vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL mthi_cycle1: got %h expected 00001234", hi); end
        vectors++; if (lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mthi_lo_kept: got %h expected ffffffff", lo); end
        do_op(OP_MADD, 32'd2, 32'd3, dc, sc, r);
        vectors++; if (dc !== 3) begin miscompares++; $display("FAIL madd_done_cycle: got %0d expected 3", dc); end
        vectors++; if (hi !== 32'h1235 || lo !== 32'h5) begin miscompares++; $display("FAIL madd_hilo: got %h_%h expected 00001235_00000005", hi, lo); end
        do_op(OP_MSUBU, 32'd2, 32'd3, dc, sc, r);
        vectors++; if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL msubu_hilo: got %h_%h expected 00001234_ffffffff", hi, lo); end
    endtask

    task automatic test_mul;
        int dc, sc;
        logic [31:0] r;
        do_op(OP_MUL, 32'h1_0000, 32'h1_0000, dc, sc, r);
        vectors++; if (dc !== 3) begin miscompares++; $display("FAIL mul_done_cycle: got %0d expected 3", dc); end
        vectors++; if (r !== 32'd0) begin miscompares++; $display("FAIL mul_result_wrap: got %h expected 00000000", r); end
        vectors++; if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mul_hilo_kept: got %h_%h expected 00001234_ffffffff", hi, lo); end
        do_op(OP_MUL, 32'd7, 32'hFFFF_FFFD, dc, sc, r);
        vectors++; if (r !== 32'hFFFF_FFEB) begin miscompares++; $display("FAIL mul_result_neg: got %h expected ffffffeb", r); end
        vectors++; if (hi !== 32'h1234 || lo !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL mul_hilo_kept2: got %h_%h expected 00001234_ffffffff", hi, lo); end
    endtask

    task automatic test_flush;
        int dc, sc, seen;
        logic [31:0] r;
        mt(OP_MTHI, 32'hAAAA);
        mt(OP_MTLO, 32'h5555);
        start = 1'b1; op = OP_DIV; a = 32'd1; flush = 1'b1;
        #1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL flush_start_stall: got %b expected 0", stall); end
        @(posedge clk); #1;
        start = 1'b0; flush = 1'b0;
        vectors++; if (stall !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL flush_start_ignored: got stall=%b done=%b expected 0/0", stall, done); end
        start = 1'b1; op = OP_DIV; a = 32'd100; b = 32'd7;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        flush = 1'b1;
        #1;
        vectors++; if (stall !== 1'b1) begin miscompares++; $display("FAIL flush_cycle10_stall: got %b expected 1", stall); end
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++; if (stall !== 1'b0 || done !== 1'b0) begin miscompares++; $display("FAIL flush_idle: got stall=%b done=%b expected 0/0", stall, done); end
        vectors++; if (hi !== 32'hAAAA || lo !== 32'h5555) begin miscompares++; $display("FAIL flush_hilo_kept: got %h_%h expected 0000aaaa_00005555", hi, lo); end
        do_op(OP_MULT, 32'd5, 32'd6, dc, sc, r);
        vectors++; if (dc !== 3) begin miscompares++; $display("FAIL post_flush_mult_cycle: got %0d expected 3", dc); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd30) begin miscompares++; $display("FAIL post_flush_mult_hilo: got %h_%h expected 00000000_0000001e", hi, lo); end
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL flush_stray_done: got %0d expected 0", seen); end
        #1;
    endtask

    task automatic test_back_to_back;
        int dc, sc;
        logic [31:0] r;
        do_op(OP_MULTU, 32'h10, 32'h10, dc, sc, r);
        vectors++; if (hi !== 32'd0 || lo !== 32'h100) begin miscompares++; $display("FAIL b2b_multu: got %h_%h expected 00000000_00000100", hi, lo); end
        do_op(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, dc, sc, r);
        vectors++; if (dc !== 3) begin miscompares++; $display("FAIL b2b_maddu_cycle: got %0d expected 3", dc); end
        vectors++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h101) begin miscompares++; $display("FAIL b2b_maddu: got %h_%h expected fffffffe_00000101", hi, lo); end
        do_op(OP_MSUB, 32'd1, 32'hFFFF_FFFF, dc, sc, r);
        vectors++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h102) begin miscompares++; $display("FAIL b2b_msub: got %h_%h expected fffffffe_00000102", hi, lo); end
    endtask

    task automatic test_reset_mid_div;
        int seen;
        start = 1'b1; op = OP_DIV; a = 32'd50; b = 32'd3;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
        end
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        vectors++; if (stall !== 1'b0) begin miscompares++; $display("FAIL rst_mid_div_stall: got %b expected 0", stall); end
        vectors++; if (hi !== 32'd0 || lo !== 32'd0) begin miscompares++; $display("FAIL rst_mid_div_hilo: got %h_%h expected 00000000_00000000", hi, lo); end
        seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done || stall) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_mid_div_quiet: got %0d active cycles expected 0", seen); end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_madd();
        test_mul();
        test_flush();
        test_back_to_back();
        test_reset_mid_div();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
